// File: rtl/l1_tag_lookup_if.sv
// Bus bundle for the L1 tag-lookup stage: probe/response, allocation and tag SRAM ports.
// The lookup stage connects through the slave modport; its environment uses master.
interface l1_tag_lookup_if #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_SET   = 32,
    parameter int NUM_WAY   = 2,
    parameter int SET_DEPTH = 5,
    parameter int WAY_DEPTH = 1
);
    logic                                 probe_valid_i;
    logic                                 probe_ready_o;
    logic [SET_DEPTH-1:0]                 probe_setid_i;
    logic [TAG_WIDTH-1:0]                 probe_tag_i;
    logic                                 resp_valid_o;
    logic                                 resp_ready_i;
    logic                                 resp_hit_o;
    logic [WAY_DEPTH-1:0]                 resp_hit_way_o;
    logic [WAY_DEPTH-1:0]                 resp_victim_way_o;
    logic                                 alloc_valid_i;
    logic                                 alloc_ready_o;
    logic [SET_DEPTH-1:0]                 alloc_setid_i;
    logic [WAY_DEPTH-1:0]                 alloc_way_i;
    logic [TAG_WIDTH-1:0]                 alloc_tag_i;
    logic                                 r_req_valid_o;
    logic [SET_DEPTH-1:0]                 r_req_setid_o;
    logic [NUM_WAY*(TAG_WIDTH+1)-1:0]     r_resp_data_i;
    logic                                 w_req_valid_o;
    logic [SET_DEPTH-1:0]                 w_req_setid_o;
    logic [NUM_WAY-1:0]                   w_req_waymask_o;
    logic [NUM_WAY*(TAG_WIDTH+1)-1:0]     w_req_data_o;

    modport slave (
        input  probe_valid_i, probe_setid_i, probe_tag_i, resp_ready_i,
               alloc_valid_i, alloc_setid_i, alloc_way_i, alloc_tag_i, r_resp_data_i,
        output probe_ready_o, resp_valid_o, resp_hit_o, resp_hit_way_o, resp_victim_way_o,
               alloc_ready_o, r_req_valid_o, r_req_setid_o,
               w_req_valid_o, w_req_setid_o, w_req_waymask_o, w_req_data_o
    );

    modport master (
        output probe_valid_i, probe_setid_i, probe_tag_i, resp_ready_i,
               alloc_valid_i, alloc_setid_i, alloc_way_i, alloc_tag_i, r_resp_data_i,
        input  probe_ready_o, resp_valid_o, resp_hit_o, resp_hit_way_o, resp_victim_way_o,
               alloc_ready_o, r_req_valid_o, r_req_setid_o,
               w_req_valid_o, w_req_setid_o, w_req_waymask_o, w_req_data_o
    );
endinterface

// File: rtl/l1_tag_lookup.sv
// L1 tag-lookup stage: clears the tag SRAM after reset, then serves probes (hit/way/victim)
// through a one-cycle compare stage and a 2-entry response FIFO, plus tag allocation writes.
module l1_tag_lookup #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_SET   = 32,
    parameter int NUM_WAY   = 2,
    parameter int SET_DEPTH = 5,
    parameter int WAY_DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    l1_tag_lookup_if.slave bus
);
    localparam int ENTRY_W = TAG_WIDTH + 1;
    localparam int DATA_W  = NUM_WAY * ENTRY_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state_reg;
    logic [SET_DEPTH-1:0] init_cnt_reg;
    logic [WAY_DEPTH-1:0] rr_ptr_reg [NUM_SET];

    logic                 s1_valid_reg;
    logic [SET_DEPTH-1:0] s1_setid_reg;
    logic [TAG_WIDTH-1:0] s1_tag_reg;

    logic                 fifo_hit_reg    [2];
    logic [WAY_DEPTH-1:0] fifo_hit_way_reg[2];
    logic [WAY_DEPTH-1:0] fifo_victim_reg [2];
    logic                 fifo_wr_ptr_reg;
    logic                 fifo_rd_ptr_reg;
    logic [1:0]           fifo_count_reg;

    logic                 run;
    logic                 in_init;
    logic                 probe_fire;
    logic                 alloc_fire;
    logic                 resp_pop;
    logic [2:0]           occupancy_next;

    logic [NUM_WAY-1:0]   way_valid;
    logic [NUM_WAY-1:0]   way_match;
    logic [NUM_WAY-1:0]   alloc_onehot;
    logic                 s1_hit;
    logic [WAY_DEPTH-1:0] s1_hit_way;
    logic [WAY_DEPTH-1:0] s1_victim;

    assign run     = (state_reg == ST_RUN);
    // Gated by rst_n so the clear writes stay quiet while reset is held.
    assign in_init = (state_reg == ST_INIT) && rst_n;

    assign resp_pop       = bus.resp_valid_o && bus.resp_ready_i;
    assign occupancy_next = {1'b0, fifo_count_reg} + 3'(s1_valid_reg) - 3'(resp_pop);

    // Allocation wins over probes so an SRAM read never meets a partial-mask write.
    assign bus.probe_ready_o = run && !bus.alloc_valid_i && (occupancy_next < 3'd2);
    assign bus.alloc_ready_o = run;
    assign probe_fire        = bus.probe_valid_i && bus.probe_ready_o;
    assign alloc_fire        = bus.alloc_valid_i && bus.alloc_ready_o;

    assign bus.r_req_valid_o = probe_fire;
    assign bus.r_req_setid_o = bus.probe_setid_i;

    generate
        for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_way
            assign way_valid[gi]    = bus.r_resp_data_i[gi*ENTRY_W + TAG_WIDTH];
            assign way_match[gi]    = way_valid[gi] &&
                                      (bus.r_resp_data_i[gi*ENTRY_W +: TAG_WIDTH] == s1_tag_reg);
            assign alloc_onehot[gi] = (bus.alloc_way_i == WAY_DEPTH'(gi));
        end
    endgenerate

    always_comb begin
        bus.w_req_valid_o   = 1'b0;
        bus.w_req_setid_o   = '0;
        bus.w_req_waymask_o = '0;
        bus.w_req_data_o    = '0;
        if (in_init) begin
            bus.w_req_valid_o   = 1'b1;
            bus.w_req_setid_o   = init_cnt_reg;
            bus.w_req_waymask_o = '1;
        end else if (alloc_fire) begin
            bus.w_req_valid_o   = 1'b1;
            bus.w_req_setid_o   = bus.alloc_setid_i;
            bus.w_req_waymask_o = alloc_onehot;
            bus.w_req_data_o    = DATA_W'({NUM_WAY{1'b1, bus.alloc_tag_i}});
        end
    end

    // Descending scans so the lowest matching / lowest invalid way is the one that sticks.
    always_comb begin
        s1_hit     = 1'b0;
        s1_hit_way = '0;
        s1_victim  = rr_ptr_reg[s1_setid_reg];
        for (int i = NUM_WAY - 1; i >= 0; i--) begin
            if (way_match[i]) begin
                s1_hit     = 1'b1;
                s1_hit_way = WAY_DEPTH'(i);
            end
            if (!way_valid[i]) begin
                s1_victim = WAY_DEPTH'(i);
            end
        end
    end

    assign bus.resp_valid_o      = (fifo_count_reg != 2'd0);
    assign bus.resp_hit_o        = fifo_hit_reg[fifo_rd_ptr_reg];
    assign bus.resp_hit_way_o    = fifo_hit_way_reg[fifo_rd_ptr_reg];
    assign bus.resp_victim_way_o = fifo_victim_reg[fifo_rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_INIT;
            init_cnt_reg    <= '0;
            s1_valid_reg    <= 1'b0;
            s1_setid_reg    <= '0;
            s1_tag_reg      <= '0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_count_reg  <= 2'd0;
            for (int i = 0; i < NUM_SET; i++) begin
                rr_ptr_reg[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                fifo_hit_reg[i]     <= 1'b0;
                fifo_hit_way_reg[i] <= '0;
                fifo_victim_reg[i]  <= '0;
            end
        end else begin
            if (state_reg == ST_INIT) begin
                init_cnt_reg <= init_cnt_reg + SET_DEPTH'(1);
                if (init_cnt_reg == SET_DEPTH'(NUM_SET - 1)) begin
                    state_reg <= ST_RUN;
                end
            end

            if (alloc_fire) begin
                rr_ptr_reg[bus.alloc_setid_i] <=
                    (bus.alloc_way_i == WAY_DEPTH'(NUM_WAY - 1)) ? '0
                                                                 : bus.alloc_way_i + WAY_DEPTH'(1);
            end

            s1_valid_reg <= probe_fire;
            if (probe_fire) begin
                s1_setid_reg <= bus.probe_setid_i;
                s1_tag_reg   <= bus.probe_tag_i;
            end

            // Flow control reserves a slot for every S1 entry, so the push is unconditional.
            if (s1_valid_reg) begin
                fifo_hit_reg[fifo_wr_ptr_reg]     <= s1_hit;
                fifo_hit_way_reg[fifo_wr_ptr_reg] <= s1_hit_way;
                fifo_victim_reg[fifo_wr_ptr_reg]  <= s1_victim;
                fifo_wr_ptr_reg                   <= ~fifo_wr_ptr_reg;
            end
            if (resp_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            fifo_count_reg <= fifo_count_reg + 2'(s1_valid_reg) - 2'(resp_pop);
        end
    end
endmodule

// File: doc/l1_tag_lookup.md
Name: l1_tag_lookup

Overview:
- Tag-lookup stage of the L1 cache; sits directly upstream of the tag `sram_template` instance.
- Drives that instance's read and write ports.
- Consumes its one-cycle-late read data, compares tags across all ways and returns hit, hit way and replacement victim.
- Performs tag allocation writes, and clears the whole array after reset before accepting traffic.

Parameters:
- TAG_WIDTH, 20: tag bits per way. Each SRAM way entry is TAG_WIDTH+1 bits, laid out as {valid, tag}.
- NUM_SET, 32: number of sets.
- NUM_WAY, 2: ways per set; must be >= 1.
- SET_DEPTH, 5: set-index width, equal to log2(NUM_SET).
- WAY_DEPTH, 1: way-index width, equal to max(1, log2(NUM_WAY)).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- probe_valid_i, in, 1: lookup request valid.
- probe_ready_o, out, 1: lookup request accepted when valid and ready are both high.
- probe_setid_i, in, SET_DEPTH: set to look up.
- probe_tag_i, in, TAG_WIDTH: tag to compare.
- resp_valid_o, out, 1: lookup result valid.
- resp_ready_i, in, 1: downstream accepts the result.
- resp_hit_o, out, 1: a valid way matched.
- resp_hit_way_o, out, WAY_DEPTH: matching way; 0 on miss.
- resp_victim_way_o, out, WAY_DEPTH: way to replace.
- alloc_valid_i, in, 1: write a tag into one way.
- alloc_ready_o, out, 1: allocation accepted.
- alloc_setid_i, in, SET_DEPTH: set to write.
- alloc_way_i, in, WAY_DEPTH: way to write.
- alloc_tag_i, in, TAG_WIDTH: tag to write; the valid bit is written as 1.
- r_req_valid_o, out, 1: SRAM read enable.
- r_req_setid_o, out, SET_DEPTH: SRAM read set.
- r_resp_data_i, in, NUM_WAY*(TAG_WIDTH+1): SRAM read data, valid the cycle after the read.
- w_req_valid_o, out, 1: SRAM write enable.
- w_req_setid_o, out, SET_DEPTH: SRAM write set.
- w_req_waymask_o, out, NUM_WAY: ways written.
- w_req_data_o, out, NUM_WAY*(TAG_WIDTH+1): write data, {valid, tag} replicated across all ways.

Behaviour:
- States:
  - INIT:
    - Entered on reset; init counter resets to 0.
    - Each cycle drives w_req_valid_o=1, w_req_setid_o=counter, waymask all ones, data 0.
    - Counter increments each cycle; after writing set NUM_SET-1 the block moves to RUN. INIT lasts exactly NUM_SET cycles.
  - RUN: normal operation; the block never leaves RUN except through reset.
- Reset values: all outputs are 0, resp FIFO empty, S1 valid 0, every per-set round-robin pointer 0.
- During INIT:
  - probe_ready_o=0 and alloc_ready_o=0.
  - r_req_valid_o=0.
- Allocation in RUN:
  - alloc_ready_o=1 in every RUN cycle.
  - On accept: w_req_valid_o=1 combinationally, setid=alloc_setid_i, waymask one-hot at alloc_way_i, every way slot carries {1, alloc_tag_i}.
  - The set's round-robin pointer updates to alloc_way_i+1, wrapping NUM_WAY-1 to 0.
- Probe/alloc priority:
  - In any cycle with alloc_valid_i=1, probe_ready_o=0, so reads and writes never collide.
  - This prevents the SRAM write bypass from returning unmerged partial-mask data.
- Probe in RUN:
  - Read port: r_req_valid_o = probe_valid_i && probe_ready_o; r_req_setid_o = probe_setid_i.
  - On accept, the setid and tag are registered into S1.
  - In the next cycle, S1 compares r_resp_data_i and pushes the result into a 2-entry output FIFO.
  - FIFO head drives resp_*; latency from accept to resp_valid_o is 2 cycles.
- Compare rules:
  - Hit = valid bit set and tag equal. With multiple hits, the lowest way wins.
  - Victim = lowest-index invalid way; if all ways are valid, the set's round-robin pointer as it stands at S1.
  - An alloc accepted while a probe to the same set is in S1 is not seen by that probe: the probe returns pre-write state.
- Flow control:
  - probe_ready_o = RUN && !alloc_valid_i && (fifo_count + s1_valid - (resp_valid_o && resp_ready_i)) < 2.
  - This gives one probe per cycle when resp_ready_i is held high.
  - The FIFO never overflows, and SRAM data is never dropped.
- NUM_WAY=1: victim and hit_way are always 0.
- Reset asserted mid-operation: S1 and FIFO contents are discarded, outputs return to reset values, and INIT restarts from set 0.

Test Plan:
- Reset release -> w_req_valid_o high for exactly 32 cycles with setid 0..31 and data 0; probe_ready_o first high on cycle 33.
- Alloc set 3 way 1 tag 0x12345, then probe set 3 tag 0x12345 -> 2 cycles after accept: resp hit=1, hit_way=1.
- Probe set 3 tag 0x00001 after that alloc -> hit=0, hit_way=0, victim=0 (way 0 still invalid).
- Fill set 5 ways 0 and 1, then 3 further allocs cycling ways -> on each miss probe, victim follows the pointer 0,1,0,... as written.
- Back-to-back probes with resp_ready_i low for 4 cycles -> exactly 2 results held, probe_ready_o low; release -> results in order, none lost.
- alloc_valid_i and probe_valid_i high in the same cycle to set 7 -> write only, probe_ready_o=0, probe accepted next cycle and sees the new tag.
